// File: rtl/fd_issue_ctrl.sv
// fd_issue_ctrl: decode-stage operand select and issue interlock.
// Decodes register-file read addresses and destination from the D-stage
// instruction, keeps a per-register pending-write counter scoreboard to
// detect RAW hazards, and sequences the single multi-cycle mult/div unit.
//
//   state   | meaning
//   --------+----------------------------------------------
//   MD_IDLE | mult/div unit free, a mult/div may issue
//   MD_BUSY | mult/div in flight, waiting for md_done pulse
module fd_issue_ctrl #(
    parameter int NUM_REGS      = 32,
    parameter int REG_AW        = 5,
    parameter int PEND_W        = 2,
    parameter int STATUS_REG    = 30,
    parameter int LINK_REG      = 31,
    parameter int OVF_TO_STATUS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       ir,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              md_done,
    output logic [REG_AW-1:0] read_a,
    output logic [REG_AW-1:0] read_b,
    output logic [REG_AW-1:0] dest,
    output logic              dest_en,
    output logic              issue,
    output logic              stall,
    output logic              md_start,
    output logic              md_busy,
    output logic              sb_any_pending
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [REG_AW-1:0] STATUS_ADDR = REG_AW'(STATUS_REG);
    localparam logic [REG_AW-1:0] LINK_ADDR   = REG_AW'(LINK_REG);
    localparam logic [PEND_W-1:0] PEND_MAX    = {PEND_W{1'b1}};

    typedef enum logic [0:0] {MD_IDLE, MD_BUSY} md_state_t;

    md_state_t         md_state;
    logic [PEND_W-1:0] cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    logic [4:0]        opcode;
    logic [4:0]        aluop;
    logic [REG_AW-1:0] rd, rs, rt;
    logic              use_a, use_b, has_dest, is_md, ovf_op, ovf_mark, hz;

    // Instruction bits that play no part in operand selection.
    logic unused_ir;
    assign unused_ir = ^{ir[11:7], ir[1:0]};

    assign opcode = ir[31:27];
    assign rd     = ir[26:22];
    assign rs     = ir[21:17];
    assign rt     = ir[16:12];
    assign aluop  = ir[6:2];

    // Decode read ports, destination and instruction class from the opcode.
    always_comb begin
        use_a    = 1'b0;
        use_b    = 1'b0;
        read_a   = '0;
        read_b   = '0;
        dest     = '0;
        has_dest = 1'b0;
        is_md    = 1'b0;
        ovf_op   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_a    = 1'b1;
                use_b    = 1'b1;
                read_a   = rs;
                read_b   = rt;
                dest     = rd;
                has_dest = 1'b1;
                is_md    = (aluop == 5'b00110) || (aluop == 5'b00111);
                ovf_op   = (aluop == 5'b00000) || (aluop == 5'b00001) || is_md;
            end
            OP_ADDI: begin
                use_a    = 1'b1;
                read_a   = rs;
                dest     = rd;
                has_dest = 1'b1;
                ovf_op   = 1'b1;
            end
            OP_LW: begin
                use_a    = 1'b1;
                read_a   = rs;
                dest     = rd;
                has_dest = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                use_a    = 1'b1;
                use_b    = 1'b1;
                read_a   = rs;
                read_b   = rd;
            end
            OP_JR: begin
                use_b    = 1'b1;
                read_b   = rd;
            end
            OP_BEX: begin
                use_b    = 1'b1;
                read_b   = STATUS_ADDR;
            end
            OP_SETX: begin
                dest     = STATUS_ADDR;
                has_dest = 1'b1;
            end
            OP_JAL: begin
                dest     = LINK_ADDR;
                has_dest = 1'b1;
            end
            OP_J:    ;
            default: ;
        endcase
    end

    assign dest_en  = has_dest && (dest != '0);
    // Status is only marked alongside a real destination write.
    assign ovf_mark = (OVF_TO_STATUS != 0) && ovf_op && dest_en;
    assign md_busy  = (md_state == MD_BUSY);

    // RAW on a used source, counter saturation on any destination, or unit busy.
    always_comb begin
        hz = 1'b0;
        if (use_a && (cnt[read_a] != '0))          hz = 1'b1;
        if (use_b && (cnt[read_b] != '0))          hz = 1'b1;
        if (dest_en && (cnt[dest] == PEND_MAX))    hz = 1'b1;
        if (ovf_mark && (cnt[STATUS_ADDR] == PEND_MAX)) hz = 1'b1;
        if (is_md && md_busy)                      hz = 1'b1;
    end

    assign issue    = in_valid && !flush && !hz && ex_ready && !reset;
    assign stall    = in_valid && !flush && (hz || !ex_ready);
    assign md_start = issue && is_md;

    // Per-register increment/decrement requests for this cycle.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue && dest_en)         inc_vec[dest] = 1'b1;
        if (issue && ovf_mark)        inc_vec[STATUS_ADDR] = 1'b1;
        if (wb_en && (wb_addr != '0)) dec_vec[wb_addr] = 1'b1;
    end

    // Scoreboard counters; simultaneous inc and dec cancel, zero never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // Reduce the scoreboard to a single any-pending flag.
    always_comb begin
        sb_any_pending = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (cnt[i] != '0) sb_any_pending = 1'b1;
    end

    // Mult/div sequencer: start on issue, release on the done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            md_state <= MD_IDLE;
        end else begin
            case (md_state)
                MD_IDLE: if (md_start) md_state <= MD_BUSY;
                MD_BUSY: if (md_done)  md_state <= MD_IDLE;
                default:               md_state <= MD_IDLE;
            endcase
        end
    end

endmodule
